// File: rtl/writeback_arbiter_pkg.sv
// Shared UArch definitions for the Blimp writeback stage.
// Holds the writeback entry layout, the channel-count ceiling and a small
// width helper used by the round-robin pointer.

`ifndef UARCH_WB_ENTRY
`define UARCH_WB_ENTRY(seq_bits_) \
    struct packed { \
        logic [31:0]             pc; \
        logic [(seq_bits_)-1:0]  seq_num; \
        logic [4:0]              waddr; \
        logic [31:0]             wdata; \
        logic                    wen; \
    }
`endif

package UArch;

    // Largest number of execute channels the writeback stage is built for.
    localparam int WB_MAX_PIPES = 8;

    // Default-width entry; modules with a different sequence-number width
    // build their own copy from the same macro.
    typedef `UARCH_WB_ENTRY(5) t_wb_entry;

    // Pointer width for an n-way round robin, never narrower than one bit.
    function automatic int prioBits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// X__W channel bundle plus register-file and completion ports of the
// writeback stage. The slave modport is the arbiter's view, the master
// modport is the environment's view.
// Optional macro WB_BYPASS_EN adds the fwd_* forwarding signals.

interface writeback_arbiter_if #(
    parameter int p_num_pipes    = 2,
    parameter int p_seq_num_bits = 5
);
    logic [p_num_pipes-1:0]                     X_val;
    logic [p_num_pipes-1:0]                     X_rdy;
    logic [p_num_pipes-1:0][31:0]               X_pc;
    logic [p_num_pipes-1:0][p_seq_num_bits-1:0] X_seq_num;
    logic [p_num_pipes-1:0][4:0]                X_waddr;
    logic [p_num_pipes-1:0][31:0]               X_wdata;
    logic [p_num_pipes-1:0]                     X_wen;

    logic                                       rf_wen;
    logic [4:0]                                 rf_waddr;
    logic [31:0]                                rf_wdata;

    logic                                       complete_val;
    logic                                       complete_rdy;
    logic [31:0]                                complete_pc;
    logic [p_seq_num_bits-1:0]                  complete_seq_num;

`ifdef WB_BYPASS_EN
    logic                                       fwd_val;
    logic [4:0]                                 fwd_waddr;
    logic [31:0]                                fwd_wdata;
`endif

    modport slave (
        input  X_val, X_pc, X_seq_num, X_waddr, X_wdata, X_wen, complete_rdy,
        output X_rdy, rf_wen, rf_waddr, rf_wdata,
               complete_val, complete_pc, complete_seq_num
`ifdef WB_BYPASS_EN
        , output fwd_val, fwd_waddr, fwd_wdata
`endif
    );

    modport master (
        output X_val, X_pc, X_seq_num, X_waddr, X_wdata, X_wen, complete_rdy,
        input  X_rdy, rf_wen, rf_waddr, rf_wdata,
               complete_val, complete_pc, complete_seq_num
`ifdef WB_BYPASS_EN
        , input fwd_val, fwd_waddr, fwd_wdata
`endif
    );

endinterface

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the priority
// pointer and moves the pointer just past the winner whenever the grant is
// actually used (en_i).

module rr_arbiter
    import UArch::*;
#(
    parameter int p_width = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [p_width-1:0]                  req_i,
    input  logic                                en_i,
    output logic [p_width-1:0]                  grant_o,
    output logic [prioBits(p_width)-1:0]        idx_o
);

    localparam int                PW        = prioBits(p_width);
    localparam logic [PW:0]       WIDTH_EXT = (PW+1)'(p_width);
    localparam logic [PW-1:0]     LAST_IDX  = PW'(p_width - 1);

    logic [PW-1:0] prio_q, prio_d;
    logic [PW:0]   candidate;
    logic          found;

    // Scan channels starting at the pointer, wrapping modulo p_width.
    always_comb begin
        found     = 1'b0;
        idx_o     = '0;
        candidate = '0;
        for (int i = 0; i < p_width; i++) begin
            candidate = {1'b0, prio_q} + (PW+1)'(i);
            if (candidate >= WIDTH_EXT) begin
                candidate = candidate - WIDTH_EXT;
            end
            if (!found && req_i[candidate[PW-1:0]]) begin
                found = 1'b1;
                idx_o = candidate[PW-1:0];
            end
        end
        grant_o = found ? (p_width'(1) << idx_o) : '0;
    end

    // Pointer advances past the winner only on a real transfer.
    always_comb begin
        prio_d = prio_q;
        if (en_i) begin
            prio_d = (idx_o == LAST_IDX) ? '0 : idx_o + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin selects one completed op per cycle from the
// execute channels, holds it in a single output register, writes the
// register file as the entry leaves and hands it to commit tracking.
// Optional macro WB_BYPASS_EN adds the fwd_* forwarding outputs.

module writeback_arbiter
    import UArch::*;
#(
    parameter int p_num_pipes    = 2,
    parameter int p_seq_num_bits = 5
) (
    input  logic              clk,
    input  logic              rst,
    writeback_arbiter_if.slave bus
);

    localparam int PW = prioBits(p_num_pipes);

    typedef `UARCH_WB_ENTRY(p_seq_num_bits) t_wb_entry_p;

    t_wb_entry_p              entry_q, entry_d;
    logic                     full_q, full_d;
    logic [p_num_pipes-1:0]   grant;
    logic [PW-1:0]            winner;
    logic                     canAccept;
    logic                     xferFire;
    logic                     drainFire;

    // Accept when empty or when the held entry leaves this cycle; nothing
    // is granted while reset is asserted.
    always_comb begin
        drainFire = full_q && bus.complete_rdy;
        canAccept = rst && (!full_q || bus.complete_rdy);
        xferFire  = canAccept && (|bus.X_val);
        bus.X_rdy = canAccept ? grant : '0;
    end

    rr_arbiter #(
        .p_width (p_num_pipes)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_i   (bus.X_val),
        .en_i    (xferFire),
        .grant_o (grant),
        .idx_o   (winner)
    );

    // Load the winner on transfer (dropping writes to x0), else drain.
    always_comb begin
        entry_d = entry_q;
        full_d  = full_q;
        if (xferFire) begin
            entry_d.pc      = bus.X_pc[winner];
            entry_d.seq_num = bus.X_seq_num[winner];
            entry_d.waddr   = bus.X_waddr[winner];
            entry_d.wdata   = bus.X_wdata[winner];
            entry_d.wen     = bus.X_wen[winner] && (bus.X_waddr[winner] != 5'd0);
            full_d          = 1'b1;
        end else if (drainFire) begin
            full_d = 1'b0;
        end
    end

    // Output register and its valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
            full_q  <= 1'b0;
        end else begin
            entry_q <= entry_d;
            full_q  <= full_d;
        end
    end

    // Completion and register-file ports come straight from the register;
    // the RF write lines up with the cycle the entry leaves.
    always_comb begin
        bus.complete_val     = full_q;
        bus.complete_pc      = entry_q.pc;
        bus.complete_seq_num = entry_q.seq_num;
        bus.rf_wen           = full_q && entry_q.wen && bus.complete_rdy;
        bus.rf_waddr         = entry_q.waddr;
        bus.rf_wdata         = entry_q.wdata;
    end

`ifdef WB_BYPASS_EN
    // Expose the pending write so decode can forward it early.
    always_comb begin
        bus.fwd_val   = full_q && entry_q.wen;
        bus.fwd_waddr = entry_q.waddr;
        bus.fwd_wdata = entry_q.wdata;
    end
`endif

    // Compact debug word: {full, wen, waddr, seq_num}.
    function automatic logic [6+p_seq_num_bits:0] trace();
        return {full_q, entry_q.wen, entry_q.waddr, entry_q.seq_num};
    endfunction

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter (two channels, 5-bit seq nums).
// Build with WB_BYPASS_EN defined to also exercise the forwarding outputs.

module tb_writeback_arbiter;

    localparam int NP = 2;
    localparam int SB = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int testsRun  = 0;
    int failCount = 0;
    int opCnt [2];
    int expWin;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.p_num_pipes(NP), .p_seq_num_bits(SB)) bus ();

    writeback_arbiter #(
        .p_num_pipes    (NP),
        .p_seq_num_bits (SB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic val, input logic [31:0] pc,
                                 input logic [4:0] seq, input logic [4:0] waddr,
                                 input logic [31:0] wdata, input logic wen);
        bus.X_val[ch]     = val;
        bus.X_pc[ch]      = pc;
        bus.X_seq_num[ch] = seq;
        bus.X_waddr[ch]   = waddr;
        bus.X_wdata[ch]   = wdata;
        bus.X_wen[ch]     = wen;
    endtask

    task automatic clearChannels();
        applyStimulus(0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [4:0] seqFor(input int c, input int k);
        return 5'(c * 8 + k);
    endfunction

    function automatic logic [4:0] waddrFor(input int c, input int k);
        return 5'(1 + c * 10 + k);
    endfunction

    function automatic logic [31:0] wdataFor(input int c, input int k);
        return 32'hA000_0000 | 32'(c << 8) | 32'(k);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with both channels requesting: nothing may be granted.
        clearChannels();
        bus.complete_rdy = 1'b1;
        applyStimulus(0, 1'b1, 32'h100, 5'd1, 5'd1, 32'h11, 1'b1);
        applyStimulus(1, 1'b1, 32'h104, 5'd2, 5'd2, 32'h22, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_complete_val", 64'(bus.complete_val), 64'h0);
        checkOutput("reset_x_rdy", 64'(bus.X_rdy), 64'h0);
        checkOutput("reset_rf_wen", 64'(bus.rf_wen), 64'h0);
        checkOutput("reset_rf_waddr", 64'(bus.rf_waddr), 64'h0);
        checkOutput("reset_rf_wdata", 64'(bus.rf_wdata), 64'h0);
        clearChannels();
        nextCycle();
        rst = 1'b1;
        settle();

        // Single op on channel 0.
        applyStimulus(0, 1'b1, 32'h200, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1);
        settle();
        checkOutput("single_x_rdy", 64'(bus.X_rdy), 64'h1);
        nextCycle();
        clearChannels();
        settle();
        checkOutput("single_complete_val", 64'(bus.complete_val), 64'h1);
        checkOutput("single_rf_wen", 64'(bus.rf_wen), 64'h1);
        checkOutput("single_rf_waddr", 64'(bus.rf_waddr), 64'h5);
        checkOutput("single_rf_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        checkOutput("single_seq", 64'(bus.complete_seq_num), 64'h3);
        checkOutput("single_pc", 64'(bus.complete_pc), 64'h200);
        nextCycle();
        checkOutput("single_drained", 64'(bus.complete_val), 64'h0);

        // Write to x0 is completed but never reaches the register file.
        bus.complete_rdy = 1'b0;
        applyStimulus(1, 1'b1, 32'h220, 5'd4, 5'd0, 32'h1234, 1'b1);
        settle();
        checkOutput("x0_x_rdy", 64'(bus.X_rdy), 64'h2);
        nextCycle();
        clearChannels();
        settle();
        checkOutput("x0_complete_val", 64'(bus.complete_val), 64'h1);
        checkOutput("x0_rf_wen_held", 64'(bus.rf_wen), 64'h0);
        bus.complete_rdy = 1'b1;
        settle();
        checkOutput("x0_rf_wen_leave", 64'(bus.rf_wen), 64'h0);
        checkOutput("x0_complete_val_leave", 64'(bus.complete_val), 64'h1);
        nextCycle();
        checkOutput("x0_drained", 64'(bus.complete_val), 64'h0);

        // Fairness: both channels busy for six ops each, pointer back at 0.
        opCnt[0] = 0;
        opCnt[1] = 0;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(c, 1'b1, 32'h1000 + 32'(c * 4), seqFor(c, 0), waddrFor(c, 0),
                          wdataFor(c, 0), 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            expWin = i % 2;
            settle();
            checkOutput($sformatf("fair_grant_%0d", i), 64'(bus.X_rdy), 64'(1 << expWin));
            nextCycle();
            checkOutput($sformatf("fair_val_%0d", i), 64'(bus.complete_val), 64'h1);
            checkOutput($sformatf("fair_seq_%0d", i), 64'(bus.complete_seq_num),
                        64'(seqFor(expWin, opCnt[expWin])));
            checkOutput($sformatf("fair_wdata_%0d", i), 64'(bus.rf_wdata),
                        64'(wdataFor(expWin, opCnt[expWin])));
            opCnt[expWin]++;
            if (opCnt[expWin] < 6) begin
                applyStimulus(expWin, 1'b1, 32'h1000 + 32'(expWin * 4), seqFor(expWin, opCnt[expWin]),
                              waddrFor(expWin, opCnt[expWin]), wdataFor(expWin, opCnt[expWin]), 1'b1);
            end else begin
                applyStimulus(expWin, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0);
            end
        end
        nextCycle();
        checkOutput("fair_drained", 64'(bus.complete_val), 64'h0);

        // Backpressure: entry held four cycles, then drain and accept together.
        bus.complete_rdy = 1'b0;
        applyStimulus(0, 1'b1, 32'h300, 5'd20, 5'd9, 32'h99, 1'b1);
        settle();
        checkOutput("bp_first_grant", 64'(bus.X_rdy), 64'h1);
        nextCycle();
        applyStimulus(0, 1'b1, 32'h304, 5'd21, 5'd10, 32'hBB, 1'b1);
        applyStimulus(1, 1'b1, 32'h308, 5'd22, 5'd11, 32'hCC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput($sformatf("bp_x_rdy_%0d", i), 64'(bus.X_rdy), 64'h0);
            checkOutput($sformatf("bp_rf_wen_%0d", i), 64'(bus.rf_wen), 64'h0);
            checkOutput($sformatf("bp_seq_%0d", i), 64'(bus.complete_seq_num), 64'd20);
            nextCycle();
        end
        bus.complete_rdy = 1'b1;
        settle();
        checkOutput("bp_release_rf_wen", 64'(bus.rf_wen), 64'h1);
        checkOutput("bp_release_rf_waddr", 64'(bus.rf_waddr), 64'd9);
        checkOutput("bp_release_rf_wdata", 64'(bus.rf_wdata), 64'h99);
        checkOutput("bp_release_grant", 64'(bus.X_rdy), 64'h2);
        nextCycle();
        checkOutput("bp_next_val", 64'(bus.complete_val), 64'h1);
        checkOutput("bp_next_seq", 64'(bus.complete_seq_num), 64'd22);
        applyStimulus(1, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0);
        settle();
        checkOutput("bp_third_grant", 64'(bus.X_rdy), 64'h1);
        nextCycle();
        checkOutput("bp_third_seq", 64'(bus.complete_seq_num), 64'd21);
        clearChannels();
        nextCycle();
        checkOutput("bp_drained", 64'(bus.complete_val), 64'h0);

        // Reset while an entry is stuck: entry discarded, pointer back to 0.
        bus.complete_rdy = 1'b0;
        applyStimulus(1, 1'b1, 32'h400, 5'd7, 5'd3, 32'h77, 1'b1);
        applyStimulus(0, 1'b1, 32'h404, 5'd8, 5'd4, 32'h88, 1'b1);
        settle();
        checkOutput("rst_pre_grant", 64'(bus.X_rdy), 64'h2);
        nextCycle();
        checkOutput("rst_pre_val", 64'(bus.complete_val), 64'h1);
        checkOutput("rst_pre_seq", 64'(bus.complete_seq_num), 64'd7);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_val", 64'(bus.complete_val), 64'h0);
        checkOutput("rst_mid_x_rdy", 64'(bus.X_rdy), 64'h0);
        checkOutput("rst_mid_rf_wen", 64'(bus.rf_wen), 64'h0);
        bus.complete_rdy = 1'b1;
        settle();
        checkOutput("rst_mid_x_rdy_crdy", 64'(bus.X_rdy), 64'h0);
        checkOutput("rst_mid_rf_wen_crdy", 64'(bus.rf_wen), 64'h0);
        nextCycle();
        rst = 1'b1;
        settle();
        checkOutput("rst_post_grant", 64'(bus.X_rdy), 64'h1);
        nextCycle();
        checkOutput("rst_post_seq", 64'(bus.complete_seq_num), 64'd8);
        checkOutput("rst_post_pc", 64'(bus.complete_pc), 64'h404);
        clearChannels();
        nextCycle();

`ifdef WB_BYPASS_EN
        // Forwarding view of a held entry, with and without a write.
        bus.complete_rdy = 1'b0;
        applyStimulus(0, 1'b1, 32'h500, 5'd9, 5'd7, 32'h55, 1'b1);
        nextCycle();
        clearChannels();
        settle();
        checkOutput("fwd_val_wen1", 64'(bus.fwd_val), 64'h1);
        checkOutput("fwd_waddr", 64'(bus.fwd_waddr), 64'd7);
        checkOutput("fwd_wdata", 64'(bus.fwd_wdata), 64'h55);
        bus.complete_rdy = 1'b1;
        nextCycle();
        bus.complete_rdy = 1'b0;
        applyStimulus(0, 1'b1, 32'h500, 5'd9, 5'd7, 32'h55, 1'b0);
        nextCycle();
        clearChannels();
        settle();
        checkOutput("fwd_held_val", 64'(bus.complete_val), 64'h1);
        checkOutput("fwd_val_wen0", 64'(bus.fwd_val), 64'h0);
        bus.complete_rdy = 1'b1;
        nextCycle();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage of the Blimp pipeline, directly downstream of the execute units (ALU, multiplier, load-store unit). Accepts completed operations over `p_num_pipes` X__W channels, selects one per cycle by round-robin, and registers it. From that register it drives the architectural register-file write port and a completion handshake toward in-order commit tracking.

## Interface
Parameters:
- `p_num_pipes`, 2: number of upstream X__W channels, 1..8.
- `p_seq_num_bits`, 5: width of the sequence number.

Ports (all per-channel buses are packed `[p_num_pipes-1:0]` arrays of the listed element width):
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset; state clears immediately when 0.
- `X_val` in 1/chan: channel holds a completed op.
- `X_rdy` out 1/chan: this cycle's grant; transfer when `X_val && X_rdy`.
- `X_pc` in 32/chan: instruction PC.
- `X_seq_num` in `p_seq_num_bits`/chan: sequence number.
- `X_waddr` in 5/chan: destination register.
- `X_wdata` in 32/chan: result data.
- `X_wen` in 1/chan: op writes a register.
- `rf_wen` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `complete_val` out 1: registered entry is valid.
- `complete_rdy` in 1: commit side accepts the entry.
- `complete_pc` out 32: PC of the registered entry.
- `complete_seq_num` out `p_seq_num_bits`: sequence number of the registered entry.

## Operation
- State:
  - one output register holding `{pc, seq_num, waddr, wdata, wen}` and a valid bit `full`;
  - round-robin pointer `prio` of width `$clog2(p_num_pipes)`, minimum 1 bit.
- Accept condition: `can_accept = !full || (complete_val && complete_rdy)`.
- Arbitration: the winner is the first channel with `X_val=1`, searching `prio, prio+1, ...` modulo `p_num_pipes`.
- Grants:
  - `X_rdy[winner] = can_accept`; every other `X_rdy` bit is 0.
  - `X_rdy` never depends on that channel's own `X_val` beyond winner selection; no combinational path from `complete_rdy` to a non-winner.
- On a transfer:
  - the register loads the winner's fields and `full` becomes 1;
  - `prio` becomes `(winner+1) mod p_num_pipes`.
- `prio` is unchanged when no transfer happens.
- x0 suppression: a loaded entry with `waddr==0` stores `wen=0`.
- Register-file write: `rf_wen = full && wen && complete_rdy`, i.e. the write happens exactly on the cycle the entry leaves.
- `rf_waddr` and `rf_wdata` show the register contents whenever `full`.
- Drain: on `complete_val && complete_rdy` with no new transfer, `full` becomes 0.
- Simultaneous drain and accept: the new entry replaces the old one with no bubble.
- Reset:
  - `full=0`, `prio=0`, register contents 0;
  - all outputs 0 (`X_rdy=0` during reset).
  - Reset asserted mid-transfer discards the entry; no RF write occurs for it.

## Timing
- Latency: an X__W transfer in cycle N gives `complete_val=1` in cycle N+1. The RF write occurs in the first cycle ≥N+1 with `complete_rdy=1`.
- Throughput: one op per cycle while `complete_rdy` stays 1.
- Backpressure: with `complete_rdy=0` and `full=1`, all `X_rdy=0`, and the register and `prio` hold.
- `complete_*` and `rf_waddr`/`rf_wdata` are driven only from the register.
- `rf_wen` and `X_rdy` have a combinational dependence on `complete_rdy`.
- Upstream channels must hold their fields stable while `X_val && !X_rdy`; this block samples only on transfer.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `fwd_val` (1), `fwd_waddr` (5) and `fwd_wdata` (32).
  - `fwd_val = full && wen`; address and data come from the register.
  - Used by decode to forward not-yet-written results.
- Undefined: these ports do not exist and no forwarding logic is built. All other behaviour is identical.

## Structure
- The shared `UArch` package holds:
  - the `t_wb_entry` packed struct `{pc, seq_num, waddr, wdata, wen}`, parameterized by seq-num width through a macro in the style of the existing MEM_REQ defines;
  - the `WB_MAX_PIPES = 8` constant.
- One sub-module, `rr_arbiter` (parameter `p_width`): takes a request vector and an `en` input; outputs a one-hot grant and the winner index; owns the `prio` register.
- The top level owns the output register, x0 suppression, handshake logic and the `trace()` function.

## Test plan
- Single op: channel 0 sends pc=0x200, seq=3, waddr=5, wdata=0xDEADBEEF, wen=1 with `complete_rdy=1`.
  - Next cycle: `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`, `complete_seq_num=3`.
- x0 write: waddr=0, wen=1, wdata=0x1234 → `complete_val=1`, `rf_wen=0` throughout.
- Fairness: both channels hold `X_val=1` continuously for 6 ops each.
  - Grants alternate 0,1,0,1,…; the register updates every cycle with no bubble.
- Backpressure: `complete_rdy=0` for 4 cycles after one transfer.
  - `X_rdy=0` on all channels, register and `rf_wen=0` hold.
  - On release, one RF write, then the next op is accepted in the same cycle.
- Reset mid-flight: assert `rst=0` while `full=1` and `complete_rdy=0`.
  - Immediately `complete_val=0`, all `X_rdy=0`.
  - After release, the first grant goes to channel 0.
- Configuration: with `WB_BYPASS_EN`, a registered entry waddr=7, wdata=0x55 gives `fwd_val=1`, `fwd_waddr=7`, `fwd_wdata=0x55`. The same entry with wen=0 gives `fwd_val=0`.
